// File: rtl/mos6502s_stack_engine.sv
// Stack sequencer for the 6502 core: multi-byte push/pull over handshaked memory beats,
// SP load, and sticky wrap-around tracking on a fixed stack page.
module mos6502s_stack_engine #(
  parameter int                    SP_WIDTH   = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100,
  parameter logic [SP_WIDTH-1:0]   RESET_SP   = 8'hFD,
  parameter int                    MAX_BYTES  = 3,
  localparam int                   CW         = $clog2(MAX_BYTES + 1),
  localparam int                   DW         = 8 * MAX_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [CW-1:0]         cmd_count,
  input  logic [DW-1:0]         cmd_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic [SP_WIDTH-1:0]   sp,
  output logic [ADDR_WIDTH-1:0] sp_addr,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic                  wrap,
  output logic [1:0]            state_dbg
);

  // Handshakes: a transfer happens on the rising edge where valid & ready are both high;
  // valid never waits on ready, and all payload is held stable while valid is high.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_PULL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SP_WIDTH-1:0] sp_q, sp_d;
  logic                wrap_q, wrap_d;
  logic [DW-1:0]       hold_q, hold_d;
  logic [CW-1:0]       rem_q, rem_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]       rsp_data_q, rsp_data_d;
  logic [SP_WIDTH-1:0] sp_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sp_q        <= RESET_SP;
      wrap_q      <= 1'b0;
      hold_q      <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      wrap_q      <= wrap_d;
      hold_q      <= hold_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    wrap_d      = wrap_q;
    hold_d      = hold_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'd0, 2'd1: begin
              if (cmd_op == 2'd1) rsp_data_d = '0;
              if (cmd_count != '0) begin
                hold_d = cmd_data;
                rem_d  = cmd_count;
                // Push walks bytes from the top down; pull fills from byte 0 upward.
                if (cmd_op == 2'd0) begin
                  idx_d   = cmd_count - 1'b1;
                  state_d = S_PUSH;
                end else begin
                  idx_d   = '0;
                  state_d = S_PULL;
                end
              end else begin
                rsp_valid_d = 1'b1;
              end
            end
            2'd2: begin
              sp_d        = cmd_data[SP_WIDTH-1:0];
              wrap_d      = 1'b0;
              rsp_valid_d = 1'b1;
            end
            default: rsp_valid_d = 1'b1;
          endcase
        end
      end
      S_PUSH: begin
        if (mem_ready) begin
          sp_d  = sp_q - 1'b1;
          if (sp_q == '0) wrap_d = 1'b1;
          rem_d = rem_q - 1'b1;
          idx_d = idx_q - 1'b1;
          if (rem_q == CW'(1)) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
          end
        end
      end
      S_PULL: begin
        if (mem_ready) begin
          sp_d  = sp_inc;
          if (&sp_q) wrap_d = 1'b1;
          rsp_data_d[{idx_q, 3'b000} +: 8] = mem_rdata;
          rem_d = rem_q - 1'b1;
          idx_d = idx_q + 1'b1;
          if (rem_q == CW'(1)) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sp_inc    = sp_q + 1'b1;
  assign sp_addr   = STACK_BASE | ADDR_WIDTH'(sp_q);
  assign top_addr  = STACK_BASE | ADDR_WIDTH'(sp_inc);
  assign cmd_ready = (state_q == S_IDLE);
  assign mem_valid = (state_q == S_PUSH) || (state_q == S_PULL);
  assign mem_we    = (state_q == S_PUSH);
  assign mem_addr  = (state_q == S_PULL) ? top_addr : sp_addr;
  assign mem_wdata = (state_q == S_PUSH) ? hold_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sp        = sp_q;
  assign wrap      = wrap_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mos6502s_stack_engine.sv
// Directed bench for mos6502s_stack_engine: push/pull ordering, wrap, stalls,
// mid-command reset and zero-beat commands, against hand-computed values.
module tb_mos6502s_stack_engine;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_count;
  logic [23:0] cmd_data;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        rsp_valid;
  logic [23:0] rsp_data;
  logic [7:0]  sp;
  logic [15:0] sp_addr;
  logic [15:0] top_addr;
  logic        wrap;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  mem [256];
  logic        saw_rsp;

  mos6502s_stack_engine dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .sp        (sp),
    .sp_addr   (sp_addr),
    .top_addr  (top_addr),
    .wrap      (wrap),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Driver: present a command at a falling edge; returns one cycle after the accept edge.
  task automatic send(input logic [1:0] op, input logic [1:0] cnt, input logic [23:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Scoreboard: every completing write beat must match the next expected {addr, data}.
  always @(negedge clk) begin
    #2;
    if (mem_valid && mem_ready && mem_we) begin
      mem[mem_addr[7:0]] = mem_wdata;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected observed=%h expected=none", {mem_addr, mem_wdata});
      end
      if (exp_q.size() != 0) chk("wr_beat", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_q.pop_front()});
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 2'd0; cmd_data = 24'h0;
    mem_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) tick();

    // Reset state
    chk("rst_sp", sp, 8'hFD);
    chk("rst_wrap", wrap, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 24'h0);
    chk("rst_mem_addr", mem_addr, 16'h01FD);
    chk("rst_top_addr", top_addr, 16'h01FE);
    rst = 1'b0;
    tick();
    chk("post_rst_sp_addr", sp_addr, 16'h01FD);

    // Push 2: 12 @ 01FD then 34 @ 01FC
    mem_ready = 1'b1;
    exp_q.push_back({16'h01FD, 8'h12});
    exp_q.push_back({16'h01FC, 8'h34});
    send(2'd0, 2'd2, 24'h001234);
    chk("p2_b1_valid", mem_valid, 1);
    chk("p2_b1_we", mem_we, 1);
    chk("p2_b1_addr", mem_addr, 16'h01FD);
    chk("p2_b1_wdata", mem_wdata, 8'h12);
    chk("p2_b1_cmd_ready", cmd_ready, 0);
    tick();
    chk("p2_b2_addr", mem_addr, 16'h01FC);
    chk("p2_b2_wdata", mem_wdata, 8'h34);
    chk("p2_b2_sp", sp, 8'hFC);
    chk("p2_b2_rsp_valid", rsp_valid, 0);
    tick();
    chk("p2_done_rsp_valid", rsp_valid, 1);
    chk("p2_done_cmd_ready", cmd_ready, 1);
    chk("p2_done_mem_valid", mem_valid, 0);
    chk("p2_done_sp", sp, 8'hFB);
    tick();
    chk("p2_rsp_one_cycle", rsp_valid, 0);

    // Pull 2: reads 01FC then 01FD
    send(2'd1, 2'd2, 24'h0);
    chk("l2_b1_addr", mem_addr, 16'h01FC);
    chk("l2_b1_we", mem_we, 0);
    tick();
    chk("l2_b2_addr", mem_addr, 16'h01FD);
    chk("l2_b2_sp", sp, 8'hFC);
    tick();
    chk("l2_done_rsp_valid", rsp_valid, 1);
    chk("l2_done_rsp_data", rsp_data, 24'h001234);
    chk("l2_done_sp", sp, 8'hFD);

    // Back-to-back: load SP=00 accepted in the rsp_valid cycle
    send(2'd2, 2'd0, 24'h000000);
    chk("ld0_rsp_valid", rsp_valid, 1);
    chk("ld0_sp", sp, 8'h00);
    chk("ld0_mem_valid", mem_valid, 0);

    // Push 1 from SP=00 wraps to FF
    exp_q.push_back({16'h0100, 8'hAB});
    send(2'd0, 2'd1, 24'h0000AB);
    chk("wr_b1_addr", mem_addr, 16'h0100);
    chk("wr_b1_wdata", mem_wdata, 8'hAB);
    tick();
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_sp", sp, 8'hFF);
    chk("wr_wrap", wrap, 1);
    chk("wr_top_addr", top_addr, 16'h0100);
    chk("wr_sp_addr", sp_addr, 16'h01FF);
    chk("wr_rsp_data_kept", rsp_data, 24'h001234);
    send(2'd2, 2'd0, 24'h000010);
    chk("ld10_sp", sp, 8'h10);
    chk("ld10_wrap_clr", wrap, 0);
    chk("ld10_rsp_valid", rsp_valid, 1);

    // Push 3 with beat 2 stalled for 4 cycles
    exp_q.push_back({16'h0110, 8'h5A});
    exp_q.push_back({16'h010F, 8'h6B});
    exp_q.push_back({16'h010E, 8'h7C});
    send(2'd0, 2'd3, 24'h5A6B7C);
    chk("p3_b1_addr", mem_addr, 16'h0110);
    chk("p3_b1_wdata", mem_wdata, 8'h5A);
    tick();
    chk("p3_b2_addr", mem_addr, 16'h010F);
    chk("p3_b2_wdata", mem_wdata, 8'h6B);
    chk("p3_b2_sp", sp, 8'h0F);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p3_stall_valid", mem_valid, 1);
      chk("p3_stall_addr", mem_addr, 16'h010F);
      chk("p3_stall_wdata", mem_wdata, 8'h6B);
      chk("p3_stall_sp", sp, 8'h0F);
    end
    mem_ready = 1'b1;
    tick();
    chk("p3_b3_addr", mem_addr, 16'h010E);
    chk("p3_b3_wdata", mem_wdata, 8'h7C);
    chk("p3_b3_sp", sp, 8'h0E);
    chk("p3_b3_rsp_valid", rsp_valid, 0);
    tick();
    chk("p3_done_rsp_valid", rsp_valid, 1);
    chk("p3_done_sp", sp, 8'h0D);
    tick();

    // Reset in the middle of a 3-byte pull
    send(2'd1, 2'd3, 24'h0);
    chk("rp_b1_addr", mem_addr, 16'h010E);
    chk("rp_b1_we", mem_we, 0);
    tick();
    chk("rp_b2_sp", sp, 8'h0E);
    chk("rp_b2_rsp_data", rsp_data, 24'h00007C);
    rst = 1'b1;
    #1;
    chk("rp_rst_mem_valid", mem_valid, 0);
    chk("rp_rst_sp", sp, 8'hFD);
    chk("rp_rst_rsp_data", rsp_data, 24'h0);
    chk("rp_rst_cmd_ready", cmd_ready, 1);
    chk("rp_rst_mem_addr", mem_addr, 16'h01FD);
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) rst = 1'b0;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("rp_no_rsp", saw_rsp, 0);

    // Count-0 push and reserved op
    chk("z_pre_rsp_valid", rsp_valid, 0);
    send(2'd0, 2'd0, 24'hFFFFFF);
    chk("z_rsp_valid", rsp_valid, 1);
    chk("z_mem_valid", mem_valid, 0);
    chk("z_sp", sp, 8'hFD);
    chk("z_rsp_data", rsp_data, 24'h0);
    tick();
    chk("z_rsp_one_cycle", rsp_valid, 0);
    send(2'd3, 2'd2, 24'h123456);
    chk("op3_rsp_valid", rsp_valid, 1);
    chk("op3_mem_valid", mem_valid, 0);
    chk("op3_sp", sp, 8'hFD);
    tick();
    chk("op3_rsp_one_cycle", rsp_valid, 0);
    chk("op3_sp_after", sp, 8'hFD);
    chk("exp_q_drained", exp_q.size(), 0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mos6502s_stack_engine.md
# mos6502s_stack_engine

Parametrised stack engine for the synthesizable 6502 core, replacing the single-step SP register with a sequencer. It executes multi-byte push and pull commands (up to MAX_BYTES per command) against a page-based stack. Each byte is issued as a handshaked memory cycle, and the pointer updates once per completed beat. It sits between the core's micro-sequencer (command side) and the memory arbiter (bus side), and tracks pointer wrap-around.

## Interface

- SP_WIDTH, 8, stack pointer width; stack depth is 2^SP_WIDTH bytes
- ADDR_WIDTH, 16, memory address width; must be >= SP_WIDTH
- STACK_BASE, 16'h0100, page base OR-ed with the zero-extended SP
- RESET_SP, 8'hFD, SP value after reset
- MAX_BYTES, 3, maximum bytes per command; CW = 2 bits covers 0..3

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE; command accepted on cmd_valid & cmd_ready
- cmd_op  in  2  0 = push, 1 = pull, 2 = load SP, 3 = reserved (treated as no-op)
- cmd_count  in  2  byte count for push/pull, 0..MAX_BYTES
- cmd_data  in  8*MAX_BYTES  push bytes (byte i = bits 8i+7:8i); load value in low SP_WIDTH bits
- mem_valid  out  1  memory beat request
- mem_ready  in  1  beat completes on mem_valid & mem_ready
- mem_we  out  1  1 = write (push), 0 = read (pull)
- mem_addr  out  ADDR_WIDTH  beat address
- mem_wdata  out  8  push byte
- mem_rdata  in  8  pull byte, sampled on the completing edge
- rsp_valid  out  1  one-cycle pulse when a command finishes
- rsp_data  out  8*MAX_BYTES  assembled pull bytes
- sp  out  SP_WIDTH  current pointer
- sp_addr  out  ADDR_WIDTH  STACK_BASE | sp (combinational)
- top_addr  out  ADDR_WIDTH  STACK_BASE | (sp+1 mod 2^SP_WIDTH) (combinational)
- wrap  out  1  sticky; set on pointer wrap, cleared by load or reset

## Operation

- FSM states:
  - IDLE: cmd_ready = 1.
  - PUSH and PULL: mem_valid = 1; mem_addr, mem_we and mem_wdata stay constant until the beat completes.
- Accept with op 0/1 and count ≥ 1:
  - Latch cmd_data into a holding register.
  - Load the beat counter with count.
  - Enter PUSH or PULL.
- Push, most-significant byte first:
  - Beat k sends byte (count-1-k) to STACK_BASE | sp.
  - On completion, sp <= sp - 1.
  - This matches the 6502 order: PCH first, then PCL.
- Pull, least-significant byte first:
  - Beat k reads STACK_BASE | (sp+1).
  - On completion, sp <= sp + 1 and byte k is captured into rsp_data[8k+7:8k].
- Pointer arithmetic is modulo 2^SP_WIDTH. Addresses never leave the page.
- wrap is set on a push beat when sp = 0 → all-ones, and on a pull beat when sp = all-ones → 0.
- Load (op 2): sp <= cmd_data[SP_WIDTH-1:0] and wrap <= 0 on the accept edge. No memory beats. rsp_valid pulses the next cycle.
- Count 0, or op 3: no beats, sp unchanged, rsp_valid pulses the next cycle.
- Count > MAX_BYTES cannot occur while MAX_BYTES = 3 and CW = 2.
- rsp_data:
  - Cleared to 0 on accepting any pull.
  - Unused upper bytes stay 0.
  - Unchanged by push, load and no-op commands.
- After the last beat, the state returns to IDLE on the same edge and rsp_valid is registered high for one cycle.
- cmd_valid is ignored outside IDLE. mem_ready is ignored when mem_valid = 0.

## Timing

- Reset values:
  - sp = RESET_SP; wrap = 0; state = IDLE.
  - cmd_ready = 1; mem_valid = 0; mem_we = 0; mem_wdata = 0.
  - rsp_valid = 0; rsp_data = 0.
  - mem_addr = STACK_BASE | RESET_SP.
- mem_addr in IDLE follows sp_addr.
- Accept at edge 0 → mem_valid high from cycle 1.
- With mem_ready tied high, an N-byte command completes beats at edges 1..N. rsp_valid is high in cycle N+1, and cmd_ready is high in that same cycle.
- Back-to-back: a new command may be accepted in the rsp_valid cycle.
- A stalled beat (mem_ready low) holds all mem outputs and sp stable.
- rst asserted mid-command:
  - Immediately forces the reset values; mem_valid drops asynchronously.
  - Beats already completed are not undone in memory, but sp returns to RESET_SP.

## Test plan

- Reset, then push count 2, cmd_data = 24'h00_12_34, mem_ready = 1 → writes 8'h12 @ 16'h01FD then 8'h34 @ 16'h01FC; sp = 8'hFB; rsp_valid in cycle 3.
- Pull count 2 from sp = 8'hFB, memory returns 8'h34 then 8'h12 → reads 16'h01FC, 16'h01FD; rsp_data = 24'h00_12_34; sp = 8'hFD.
- Load 8'h00, then push count 1 → write @ 16'h0100; sp = 8'hFF; wrap = 1. A following load 8'h10 clears wrap.
- Push count 3 with mem_ready low for 4 cycles on beat 2 → mem_addr and mem_wdata held constant; sp changes only on completing edges; total latency 7 cycles.
- Assert rst mid-pull (after beat 1) → mem_valid = 0 immediately; sp = 8'hFD; rsp_data = 0; rsp_valid is never pulsed.
- Count-0 push and op 3 → no mem_valid, sp unchanged, single rsp_valid pulse one cycle after accept.
